regfile_wb: RTL
===============

REGFILE_WB -- requirements
Module: regfile_wb

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width; depth is 2**ADDR_W (32).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port we_i  input  1  write enable from the execute-result path (wreg).
REQ-006 SHALL have port waddr_i  input  ADDR_W  destination register (wd).
REQ-007 SHALL have port wdata_i  input  DATA_W  write data (wdata).
REQ-008 SHALL have ports re1_i / re2_i  input  1  read enables, ports 1 and 2.
REQ-009 SHALL have ports raddr1_i / raddr2_i  input  ADDR_W  read addresses.
REQ-010 SHALL have ports rdata1_o / rdata2_o  output  DATA_W  combinational read data.
REQ-011 SHALL have port busy_o  output  1  high while the clear sweep runs.
REQ-012 SHALL have port wr_drop_o  output  1  sticky flag: a write was dropped during the sweep.

Function
REQ-013 SHALL implement two states: INIT (clearing) and READY.
REQ-014 In INIT, SHALL write zero to entry clr_ptr each cycle, clr_ptr incrementing from 0.
REQ-015 In INIT with clr_ptr == 31, SHALL go to READY on the next edge; the sweep lasts 32 cycles.
REQ-016 busy_o SHALL be high only in INIT.
REQ-017 In READY, with we_i=1 and waddr_i!=0, SHALL write wdata_i to entry waddr_i on the rising edge.
REQ-018 Writes to address 0 SHALL be ignored; entry 0 reads as zero always.
REQ-019 In INIT, with we_i=1 and waddr_i!=0, SHALL drop the write and set wr_drop_o=1 on the next edge.
REQ-020 wr_drop_o SHALL hold until rst.
REQ-021 Each read port SHALL output zero when rst=1, state is INIT, its re=0, or its raddr=0.
REQ-022 Otherwise, each read port SHALL output the stored entry at its raddr, with zero added latency.
REQ-023 Both ports reading the same address SHALL return identical data.
REQ-024 With both ports enabled and the write active to the same address, both SHALL bypass identically (see Configuration).

Reset
REQ-025 On an edge with rst=1, SHALL set the state to INIT, clr_ptr to 0 and wr_drop_o to 0.
REQ-026 Stored entries SHALL NOT be cleared directly by rst; the sweep SHALL clear them.
REQ-027 busy_o SHALL be 1 in the first cycle after rst deasserts.
REQ-028 rst asserted mid-sweep or in READY SHALL restart the full 32-cycle sweep from entry 0.
REQ-029 In the same edge as rst, SHALL not perform any write.

Configuration
REQ-030 Macro REGFILE_BYPASS_EN defined: in READY, a read with re=1, raddr!=0, we_i=1 and waddr_i==raddr SHALL return wdata_i in the same cycle (write-through forwarding).
REQ-031 Macro REGFILE_BYPASS_EN undefined: that read SHALL return the old stored value; the new value SHALL be visible from the cycle after the write edge.

Verification
REQ-032 Release rst, then poll -> busy_o=1 for exactly 32 cycles, then 0; reads of r1..r31 = 0x00000000.
REQ-033 In READY, write r5=0xDEADBEEF; next cycle set re1=1, raddr1=5 -> rdata1_o=0xDEADBEEF.
REQ-034 In READY, write r0=0x12345678; read r0 on both ports -> 0x00000000.
REQ-035 At cycle 3 of the sweep, set we=1, waddr=7, wdata=0xA5A5A5A5 -> wr_drop_o=1 stays set; after READY, read r7 -> 0.
REQ-036 Same cycle: we=1, waddr=9, wdata=0x0000CAFE and re1=re2=1, raddr1=raddr2=9, with r9 previously 0x11 -> both ports 0x0000CAFE with REGFILE_BYPASS_EN, 0x00000011 without; both 0x0000CAFE next cycle.
REQ-037 Write r3=0x55, then assert rst for 1 cycle -> busy_o=1 for 32 cycles, wr_drop_o=0, r3 reads 0 afterward.

Source files
------------

// File: rtl/regfile_wb.sv
// Two-read/one-write register file; entry 0 is hardwired to zero. A 32-cycle clear sweep runs after every rst.
// Reads are combinational with zero added latency. Writes land on the clock edge. REGFILE_BYPASS_EN forwards same-cycle write data to the read ports.
// No backpressure: writes issued during the sweep are dropped and latched into the sticky wr_drop_o flag.
module regfile_wb #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              re1_i,
   input  logic [ADDR_W-1:0] raddr1_i,
   input  logic              re2_i,
   input  logic [ADDR_W-1:0] raddr2_i,
   output logic [DATA_W-1:0] rdata1_o,
   output logic [DATA_W-1:0] rdata2_o,
   output logic              busy_o,
   output logic              wr_drop_o
);

   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic {ST_INIT, ST_READY} state_t;

   state_t            state;
   logic [ADDR_W-1:0] clr_ptr;
   logic              wr_drop;
   logic [DATA_W-1:0] mem [DEPTH];

   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;
   logic              wr_req;

   assign wr_req = we_i && (waddr_i != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_INIT;
         clr_ptr <= '0;
         wr_drop <= 1'b0;
      end else begin
         case (state)
            ST_INIT: begin
               clr_ptr <= clr_ptr + 1'b1;
               if (clr_ptr == {ADDR_W{1'b1}})
                  state <= ST_READY;
               if (wr_req)
                  wr_drop <= 1'b1;
            end
            default: state <= ST_READY;
         endcase
      end
   end

   // The array has no reset of its own; the sweep and the write path share one port.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = clr_ptr;
      mem_wdata = '0;
      if (!rst) begin
         if (state == ST_INIT) begin
            mem_we = 1'b1;
         end else if (wr_req) begin
            mem_we    = 1'b1;
            mem_waddr = waddr_i;
            mem_wdata = wdata_i;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we)
         mem[mem_waddr] <= mem_wdata;
   end

   logic rd_block;
   logic byp1;
   logic byp2;

   assign rd_block = rst || (state == ST_INIT);

`ifdef REGFILE_BYPASS_EN
   assign byp1 = we_i && (waddr_i == raddr1_i);
   assign byp2 = we_i && (waddr_i == raddr2_i);
`else
   assign byp1 = 1'b0;
   assign byp2 = 1'b0;
`endif

   always_comb begin
      rdata1_o = '0;
      if (!rd_block && re1_i && (raddr1_i != '0))
         rdata1_o = byp1 ? wdata_i : mem[raddr1_i];
   end

   always_comb begin
      rdata2_o = '0;
      if (!rd_block && re2_i && (raddr2_i != '0))
         rdata2_o = byp2 ? wdata_i : mem[raddr2_i];
   end

   assign busy_o    = (state == ST_INIT);
   assign wr_drop_o = wr_drop;

endmodule
